adc_frame_sync: RTL and testbench

ADC_FRAME_SYNC -- requirements
Module: adc_frame_sync

---
 rtl/adc_frame_pkg.sv | 21 ++
 rtl/tick_delay.sv | 73 +++++++
 rtl/adc_frame_sync.sv | 151 +++++++++++++++
 tb/tb_adc_frame_sync.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame synchroniser.
package adc_frame_pkg;

    // Delay FSM: waiting for a tick, or counting toward the capture strobe.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } dly_state_t;

    // Output stage: holding no frame, or holding one not yet accepted downstream.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    localparam int MAX_CH    = 16;
    localparam int DROP_W    = 16;
    localparam int SUM_GUARD = 4;
    localparam int DCNT_W    = 9;

endpackage

// File: rtl/tick_delay.sv
// Delay FSM: converts each ADC data-ready tick into a one-cycle capture
// strobe DELAY cycles later. A tick while counting restarts the count and
// reports a retrigger; a tick on the strobe cycle keeps that strobe.
module tick_delay
    import adc_frame_pkg::*;
#(
    parameter int DELAY = 100
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    output logic cap_o,
    output logic retrig_o
);

    localparam logic [DCNT_W-1:0] LAST = DCNT_W'(DELAY - 1);

    dly_state_t        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              at_last;

    assign at_last = (state_q == COUNT) && (dcnt_q == LAST);

    // Next-state logic: count toward LAST, restart on any tick.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        cap_o    = 1'b0;
        retrig_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    state_d = COUNT;
                    dcnt_d  = '0;
                end
            end
            COUNT: begin
                if (at_last) begin
                    cap_o   = 1'b1;
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
                // A tick restarts the count; it only loses a frame when it
                // lands before the strobe rather than on it.
                if (tick_i) begin
                    state_d  = COUNT;
                    dcnt_d   = '0;
                    retrig_o = !at_last;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any pending strobe.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

endmodule

// File: rtl/adc_frame_sync.sv
// ADC frame synchroniser: delays each tick, captures all channels into a
// one-deep valid/ready output stage, and counts captures and lost frames.
// Optional masked channel sum enabled by defining ADC_FRAME_SUM_EN.
module adc_frame_sync
    import adc_frame_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 24,
    parameter int DELAY  = 100,
    parameter int CNT_W  = 33
`ifdef ADC_FRAME_SUM_EN
    ,
    parameter logic [NUM_CH-1:0] SUM_MASK = {NUM_CH{1'b1}}
`endif
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_i,
    input  logic                       ready_i,
    output logic [NUM_CH*DATA_W-1:0]   frame_o,
    output logic                       valid_o,
    output logic [CNT_W-1:0]           count_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic                       overrun_o
`ifdef ADC_FRAME_SUM_EN
    ,
    output logic signed [DATA_W+SUM_GUARD-1:0] sum_o
`endif
);

    localparam int FRAME_W = NUM_CH * DATA_W;

    logic               cap;
    logic               retrig;
    logic               load;
    logic               lost;
    out_state_t         out_state_q, out_state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               overrun_q, overrun_d;

    tick_delay #(
        .DELAY(DELAY)
    ) u_tick_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick_i  (tick_i),
        .cap_o   (cap),
        .retrig_o(retrig)
    );

    // Output stage: load on strobe when there is room (or room is being made
    // by a same-cycle handshake), otherwise keep the old frame and flag overrun.
    always_comb begin
        out_state_d = out_state_q;
        frame_d     = frame_q;
        count_d     = count_q;
        drop_d      = drop_q;
        overrun_d   = overrun_q;
        load        = 1'b0;
        lost        = 1'b0;
        case (out_state_q)
            EMPTY: begin
                if (cap) begin
                    load        = 1'b1;
                    out_state_d = FULL;
                end
            end
            FULL: begin
                if (cap && ready_i) begin
                    load = 1'b1;
                end else if (cap) begin
                    lost = 1'b1;
                end else if (ready_i) begin
                    out_state_d = EMPTY;
                end
            end
            default: out_state_d = EMPTY;
        endcase
        if (load) begin
            frame_d = ch_i;
            count_d = count_q + CNT_W'(1);
        end
        if (lost) begin
            overrun_d = 1'b1;
        end
        // Retrigger and lost capture are mutually exclusive (one needs the
        // strobe, the other excludes it), so a single saturating step suffices.
        if ((retrig || lost) && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // Output-stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_state_q <= EMPTY;
            // NOTE: the frame register is datapath, but it is reset because downstream may read frame_o as zero after reset.
            frame_q     <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            frame_q     <= frame_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_o    = frame_q;
    assign valid_o    = (out_state_q == FULL);
    assign count_o    = count_q;
    assign drop_cnt_o = drop_q;
    assign overrun_o  = overrun_q;

`ifdef ADC_FRAME_SUM_EN
    localparam int SUM_W = DATA_W + SUM_GUARD;

    logic signed [SUM_W-1:0] sum_q, sum_d;

    // Masked sum of the incoming channels, sign-extended per channel; the
    // guard bits cover up to MAX_CH full-scale channels without overflow.
    always_comb begin
        sum_d = sum_q;
        if (load) begin
            sum_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (SUM_MASK[k]) begin
                    sum_d = sum_d + SUM_W'($signed(ch_i[k*DATA_W +: DATA_W]));
                end
            end
        end
    end

    // Sum register, loaded on the same strobe as the frame.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`endif

endmodule

// File: tb/tb_adc_frame_sync.sv
// Self-checking bench for adc_frame_sync: directed steps with a scoreboard
// of expected frames pushed on stimulus and popped when a frame is presented.
module tb_adc_frame_sync;

    localparam int NUM_CH  = 8;
    localparam int DATA_W  = 24;
    localparam int DELAY   = 100;
    localparam int CNT_W   = 4;
    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int SUM_W   = DATA_W + 4;
    localparam int LAT     = DELAY + 1;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               tick_i;
    logic               ready_i;
    logic [FRAME_W-1:0] ch_i;
    logic [FRAME_W-1:0] frame_o;
    logic               valid_o;
    logic [CNT_W-1:0]   count_o;
    logic [15:0]        drop_cnt_o;
    logic               overrun_o;
`ifdef ADC_FRAME_SUM_EN
    logic signed [SUM_W-1:0] sum_o;
`endif

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic [CNT_W-1:0]   count;
    } exp_t;

    exp_t             sb[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               t;
    int               t2;
    logic             saw;
    logic             stable;
    logic [CNT_W-1:0] exp_count = '0;
    logic [15:0]      exp_drop  = '0;
    logic             exp_ovr   = 1'b0;
    logic [FRAME_W-1:0] d1, d2, dc, dd, de, df, dn;

    adc_frame_sync #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .DELAY (DELAY),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .tick_i    (tick_i),
        .ch_i      (ch_i),
        .ready_i   (ready_i),
        .frame_o   (frame_o),
        .valid_o   (valid_o),
        .count_o   (count_o),
        .drop_cnt_o(drop_cnt_o),
        .overrun_o (overrun_o)
`ifdef ADC_FRAME_SUM_EN
        ,
        .sum_o     (sum_o)
`endif
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    function automatic logic [FRAME_W-1:0] pack(input int base, input int step);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(base + step * k);
        return f;
    endfunction

`ifdef ADC_FRAME_SUM_EN
    function automatic logic signed [SUM_W-1:0] model_sum(input logic [FRAME_W-1:0] f);
        longint s;
        logic signed [DATA_W-1:0] c;
        s = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = f[k*DATA_W +: DATA_W];
            s = s + longint'(c);
        end
        return SUM_W'(s);
    endfunction
`endif

    // Record a capture the model expects to be accepted.
    task automatic push_exp(input logic [FRAME_W-1:0] data);
        exp_t e;
        exp_count = exp_count + 1'b1;
        e.frame   = data;
        e.count   = exp_count;
        sb.push_back(e);
    endtask

    // Compare the presented frame against the oldest expectation.
    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_has_entry"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_frame"}, frame_o, e.frame);
            check({tag, "_count"}, count_o, e.count);
`ifdef ADC_FRAME_SUM_EN
            check({tag, "_sum"}, sum_o, model_sum(e.frame));
`endif
        end
    endtask

    task automatic fire_tick(input logic [FRAME_W-1:0] data, output int tt);
        ch_i   = data;
        tick_i = 1'b1;
        tt     = cyc;
        cycle(1);
        tick_i = 1'b0;
    endtask

    // Bounded wait for valid_o; checks the cycle distance from a tick.
    task automatic wait_valid(input int t0, input int lat, input string tag);
        int budget;
        budget = 0;
        while (valid_o !== 1'b1 && budget < 400) begin
            cycle(1);
            budget++;
        end
        check(tag, cyc - t0, lat);
    endtask

    initial begin
        reset_i = 1'b1;
        tick_i  = 1'b0;
        ready_i = 1'b1;
        ch_i    = '0;
        d1 = pack(1, 1);
        d2 = pack(-3000, 1000);
        dc = pack('h123456, 7);
        dd = pack(-1, -1);
        de = pack(500, -77);
        df = pack('h7FFFF0, -3);
        dn = pack(-(1 << (DATA_W - 1)), 0);

        // Reset, with a tick present during reset that must be ignored.
        cycle(1);
        tick_i = 1'b1;
        cycle(2);
        reset_i = 1'b0;
        tick_i  = 1'b0;
        check("rst_valid", valid_o, 1'b0);
        check("rst_frame", frame_o, '0);
        check("rst_count", count_o, '0);
        check("rst_drop", drop_cnt_o, '0);
        check("rst_overrun", overrun_o, 1'b0);
`ifdef ADC_FRAME_SUM_EN
        check("rst_sum", sum_o, '0);
`endif
        saw = 1'b0;
        repeat (150) begin
            cycle(1);
            saw = saw | valid_o;
        end
        check("rst_tick_ignored", saw, 1'b0);

        // Basic latency with ready high.
        push_exp(d1);
        fire_tick(d1, t);
        wait_valid(t, LAT, "basic_lat");
        pop_check("basic");
        check("basic_overrun", overrun_o, 1'b0);
        cycle(1);
        check("basic_hs_empty", valid_o, 1'b0);

        // Retrigger 50 cycles after the first tick.
        push_exp(d2);
        fire_tick(d2, t);
        cycle(49);
        fire_tick(d2, t2);
        exp_drop = exp_drop + 1'b1;
        wait_valid(t, 50 + LAT, "retrig_lat");
        pop_check("retrig");
        check("retrig_drop", drop_cnt_o, exp_drop);
        check("retrig_overrun", overrun_o, 1'b0);
        cycle(1);
        check("retrig_hs_empty", valid_o, 1'b0);

        // Backpressure: second capture lands on a held frame.
        ready_i = 1'b0;
        push_exp(dc);
        fire_tick(dc, t);
        wait_valid(t, LAT, "bp_lat");
        cycle(99);
        fire_tick(dd, t2);
        exp_drop = exp_drop + 1'b1;
        exp_ovr  = 1'b1;
        stable   = 1'b1;
        repeat (105) begin
            cycle(1);
            if (frame_o !== dc || valid_o !== 1'b1) stable = 1'b0;
        end
        check("bp_frame_hold", stable, 1'b1);
        check("bp_overrun", overrun_o, exp_ovr);
        check("bp_drop", drop_cnt_o, exp_drop);
        pop_check("bp");
        ready_i = 1'b1;
        cycle(1);
        check("bp_release", valid_o, 1'b0);

        // Tick on the strobe cycle, then capture coinciding with a handshake.
        ready_i = 1'b0;
        push_exp(de);
        fire_tick(de, t);
        cycle(99);
        check("cc_pre_valid", valid_o, 1'b0);
        push_exp(df);
        fire_tick(de, t2);
        ch_i = df;
        check("cc_first_valid", valid_o, 1'b1);
        check("cc_first_lat", cyc - t, LAT);
        cycle(99);
        check("cc_hold_valid", valid_o, 1'b1);
        pop_check("cc_old");
        ready_i = 1'b1;
        cycle(1);
        check("cc_valid_kept", valid_o, 1'b1);
        pop_check("cc_new");
        check("cc_no_drop", drop_cnt_o, exp_drop);
        check("cc_overrun_sticky", overrun_o, 1'b1);
        cycle(1);
        check("cc_hs_empty", valid_o, 1'b0);

        // Reset 40 cycles into a count aborts the capture.
        fire_tick(d1, t);
        cycle(39);
        reset_i = 1'b1;
        cycle(1);
        reset_i   = 1'b0;
        exp_count = '0;
        exp_drop  = '0;
        exp_ovr   = 1'b0;
        sb.delete();
        saw = 1'b0;
        repeat (200) begin
            cycle(1);
            saw = saw | valid_o;
        end
        check("midrst_no_valid", saw, 1'b0);
        check("midrst_count", count_o, '0);
        check("midrst_drop", drop_cnt_o, '0);
        check("midrst_overrun", overrun_o, 1'b0);

        // Counter wrap and most-negative full-scale sum.
        ready_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_exp(dn);
            fire_tick(dn, t);
            wait_valid(t, LAT, "wrap_lat");
            pop_check("wrap");
            cycle(1);
        end
        check("wrap_count", count_o, 4'd1);
        check("wrap_frame", frame_o, dn);
`ifdef ADC_FRAME_SUM_EN
        check("wrap_sum_min", sum_o, -(SUM_W'(NUM_CH) << (DATA_W - 1)));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
